// File: rtl/aes_pkg.sv
// Shared helpers for the AES inverse cipher: inverse S-box, block byte-order
// conversion, GF(2^8) constant multiplies and the decryptor FSM state type.
package aes_pkg;

  localparam int NR_AES = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } dec_state_e;

  // Row-major inverse S-box; entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[8*(255 - int'(b)) +: 8];
  endfunction

  // External order has block byte 0 in the MSB; internal order has it in the LSB.
  function automatic logic [127:0] changeEndian(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = d[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One inverse AES round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] st_next
);

  logic [127:0] tmp;
  logic [127:0] mixed;

  generate
    // Byte gi holds row gi%4, column gi/4; row r is rotated right by r columns.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi % 4;
      localparam int SRC = ROW + 4 * (((gi / 4) - ROW + 4) % 4);
      assign tmp[8*gi +: 8] = inv_sbox(st[8*SRC +: 8]) ^ rk[8*gi +: 8];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = tmp[32*gi +: 8];
      assign a1 = tmp[32*gi + 8 +: 8];
      assign a2 = tmp[32*gi + 16 +: 8];
      assign a3 = tmp[32*gi + 24 +: 8];
      assign mixed[32*gi +: 8]      = gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3);
      assign mixed[32*gi + 8 +: 8]  = gf_mul9(a0) ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3);
      assign mixed[32*gi + 16 +: 8] = gf_mul13(a0) ^ gf_mul9(a1) ^ gf_mul14(a2) ^ gf_mul11(a3);
      assign mixed[32*gi + 24 +: 8] = gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2) ^ gf_mul14(a3);
    end
  endgenerate

  assign st_next = last ? tmp : mixed;

endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, valid/ready on both sides.
// Define AES_DEC_CBC_EN to add CBC unchaining through the iv / iv_load ports.
module aes_128_dec_iter
  import aes_pkg::*;
#(
  parameter int NR = NR_AES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [128*(NR+1)-1:0] expandedKey,
`ifdef AES_DEC_CBC_EN
  input  logic [127:0]          iv,
  input  logic                  iv_load,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data
);

  localparam int RW = $clog2(NR);

  dec_state_e    state_reg, state_next;
  logic [127:0]  st_reg, st_next;
  logic [RW-1:0] rcnt_reg, rcnt_next;
  logic [127:0]  out_data_reg, out_data_next;
  logic [127:0]  rk_arr [0:NR];
  logic [127:0]  round_out;
  logic [127:0]  chain_cur;
  logic          last_round;

  generate
    for (genvar gi = 0; gi <= NR; gi++) begin : g_rk
      assign rk_arr[gi] = expandedKey[128*gi +: 128];
    end
  endgenerate

  assign last_round = (rcnt_reg == '0);

  aes_inv_round u_round (
    .st      (st_reg),
    .rk      (rk_arr[rcnt_reg]),
    .last    (last_round),
    .st_next (round_out)
  );

`ifdef AES_DEC_CBC_EN
  logic [127:0] chain_reg, chain_next;
  logic [127:0] ct_hold_reg, ct_hold_next;

  // iv_load is applied at the same edge as an accept, so that block sees the new iv.
  always_comb begin
    chain_next   = chain_reg;
    ct_hold_next = ct_hold_reg;
    if (state_reg == IDLE) begin
      if (iv_load)  chain_next   = iv;
      if (in_valid) ct_hold_next = in_data;
    end else if (state_reg == DONE && out_ready) begin
      chain_next = ct_hold_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_reg   <= '0;
      ct_hold_reg <= '0;
    end else begin
      chain_reg   <= chain_next;
      ct_hold_reg <= ct_hold_next;
    end
  end

  assign chain_cur = chain_reg;
`else
  assign chain_cur = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)   state_next = ROUND;
      ROUND:   if (last_round) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  // Plaintext is registered on the final round so it stays put until the next block finishes.
  always_comb begin
    st_next       = st_reg;
    rcnt_next     = rcnt_reg;
    out_data_next = out_data_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          st_next   = changeEndian(in_data) ^ rk_arr[NR];
          rcnt_next = RW'(NR - 1);
        end
      end
      ROUND: begin
        st_next = round_out;
        if (last_round) out_data_next = changeEndian(round_out) ^ chain_cur;
        else            rcnt_next     = rcnt_reg - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_reg       <= '0;
      rcnt_reg     <= '0;
      out_data_reg <= '0;
    end else begin
      st_reg       <= st_next;
      rcnt_reg     <= rcnt_next;
      out_data_reg <= out_data_next;
    end
  end

  assign out_data = out_data_reg;

endmodule

// File: tb/tb_aes_128_dec_iter.sv
// Self-checking bench for aes_128_dec_iter: known-answer table, handshake corner
// cases, and a random round-trip against a forward AES model built from GF(2^8) arithmetic.
module tb_aes_128_dec_iter;

  localparam int NR = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [128*(NR+1)-1:0] expandedKey;
  logic                  in_valid;
  logic                  in_ready;
  logic [127:0]          in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [127:0]          out_data;
`ifdef AES_DEC_CBC_EN
  logic [127:0]          iv;
  logic                  iv_load;
  bit                    cbc_mode = 1'b0;
  logic [127:0]          cbc_ct [4];
  logic [127:0]          cbc_pt [4];
`endif

  int checks = 0;
  int errors = 0;
  int blk_n  = 0;

  logic [7:0] sbox_t [256];
  logic [7:0] rkb [11][16];

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  vec_t vecs [3];

  always #5 clk = ~clk;

  aes_128_dec_iter #(.NR(NR)) dut (
    .clk         (clk),
    .rst         (rst),
    .expandedKey (expandedKey),
`ifdef AES_DEC_CBC_EN
    .iv          (iv),
    .iv_load     (iv_load),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [7:0] w [44][4];
    logic [7:0] t [4];
    logic [7:0] t0;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 4; b++) w[i][b] = key[127 - 8*(4*i + b) -: 8];
    for (int i = 4; i < 44; i++) begin
      for (int b = 0; b < 4; b++) t[b] = w[i-1][b];
      if (i % 4 == 0) begin
        t0   = t[0];
        t[0] = sbox_t[t[1]] ^ rc;
        t[1] = sbox_t[t[2]];
        t[2] = sbox_t[t[3]];
        t[3] = sbox_t[t0];
        rc   = gmul(rc, 8'h02);
      end
      for (int b = 0; b < 4; b++) w[i][b] = w[i-4][b] ^ t[b];
    end
    for (int r = 0; r < 11; r++)
      for (int j = 0; j < 16; j++) begin
        rkb[r][j] = w[4*r + j/4][j%4];
        expandedKey[128*r + 8*j +: 8] = rkb[r][j];
      end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] ct;
    for (int j = 0; j < 16; j++) s[j] = pt[127 - 8*j -: 8] ^ rkb[0][j];
    for (int r = 1; r <= NR; r++) begin
      for (int j = 0; j < 16; j++) t[j] = sbox_t[s[j]];
      for (int j = 0; j < 16; j++) s[j] = t[(j % 4) + 4 * (((j / 4) + (j % 4)) % 4)];
      if (r < NR) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int j = 0; j < 16; j++) s[j] ^= rkb[r][j];
    end
    for (int j = 0; j < 16; j++) ct[127 - 8*j -: 8] = s[j];
    return ct;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge with the core idle; returns at a negedge with the core idle again.
  task automatic do_block(input logic [127:0] ct, input logic [127:0] exp);
    int lat;
    logic [127:0] got;
    check("in_ready_idle", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1;
    in_data  = ct;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand128();
`ifdef AES_DEC_CBC_EN
    if (cbc_mode) iv_load = 1'b0;
`endif
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got = out_data;
    check("latency", 128'(lat), 128'(NR));
    check("out_data", got, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", {127'd0, out_valid}, 128'd0);
    check("data_hold", out_data, exp);
    blk_n++;
    $display("blk %0d ct=%h pt=%h lat=%0d", blk_n, ct, got, lat);
  endtask

  initial begin
    logic [127:0] pa, pb, ca, cb, ps, cs;
    logic [127:0] got;
    int busy, lat, cnt;

    build_sbox();
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; expandedKey = '0;
`ifdef AES_DEC_CBC_EN
    iv = '0; iv_load = 1'b1;
`endif
    repeat (2) @(negedge clk);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Known-answer table
    for (int v = 0; v < 3; v++) begin
      set_key(vecs[v].key);
      do_block(vecs[v].ct, vecs[v].pt);
    end

    // Back-to-back with out_ready held high
    pa = rand128(); pb = rand128(); ca = encrypt(pa); cb = encrypt(pb);
    check("b2b_ready", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b1; in_data = ca; out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      if (b == 0) in_data = cb;
      else        in_valid = 1'b0;
      busy = 0; got = '0;
      while (!in_ready && busy < 40) begin
        if (out_valid) got = out_data;
        busy++;
        @(negedge clk);
      end
      check("b2b_busy", 128'(busy), 128'd11);
      check("b2b_data", got, (b == 0) ? pa : pb);
      $display("b2b blk %0d busy=%0d pt=%h", b, busy, got);
    end
    out_ready = 1'b0;

    // Output stall with ignored in_valid pulses
    ps = rand128(); cs = encrypt(ps);
    in_valid = 1'b1; in_data = cs;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("stall_lat", 128'(lat), 128'(NR));
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = rand128();
      @(negedge clk);
      check("stall_valid", {127'd0, out_valid}, 128'd1);
      check("stall_data", out_data, ps);
      check("stall_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_release_valid", {127'd0, out_valid}, 128'd0);
    check("stall_release_ready", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    check("stall_no_latch", {127'd0, in_ready}, 128'd1);
    $display("stall pt=%h", ps);

    // Reset in round 4 discards the block
    pa = rand128(); ca = encrypt(pa);
    in_valid = 1'b1; in_data = ca;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    check("midrst_out_data", out_data, 128'd0);
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("midrst_discard", 128'(cnt), 128'd0);
    $display("midrst discarded=%0d", (cnt == 0));
    do_block(ca, pa);

    // Reset together with in_valid: nothing accepted
    rst = 1'b1; in_valid = 1'b1; in_data = ca;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("rst_vs_valid", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    check("rst_vs_valid_hold", {127'd0, in_ready}, 128'd1);
    $display("rst with in_valid: in_ready=%0b", in_ready);

    // Random round-trip through the forward model
    for (int n = 0; n < 1000; n++) begin
      if (n % 250 == 0) set_key(rand128());
      pa = rand128();
      do_block(encrypt(pa), pa);
    end

`ifdef AES_DEC_CBC_EN
    cbc_ct[0] = 128'h7649abac8119b246cee98e9b12e9197d;
    cbc_ct[1] = 128'h5086cb9b507219ee95db113a917678b2;
    cbc_ct[2] = 128'h73bed6b8e3c1743b7116e69e22229516;
    cbc_ct[3] = 128'h3ff1caa1681fac09120eca307586e1a7;
    cbc_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    cbc_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    cbc_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    cbc_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    cbc_mode = 1'b1;
    iv = 128'h000102030405060708090a0b0c0d0e0f;
    iv_load = 1'b1;
    for (int k = 0; k < 4; k++) do_block(cbc_ct[k], cbc_pt[k]);
    cbc_mode = 1'b0; iv = '0; iv_load = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
